// File: rtl/i2c_slave_gen2.sv
// I2C slave with register read/write interface, filtered Sclk/Sda and 8/16-bit addressing.
// Build option: define I2C_SLV_AUTOINC_EN to advance the address pointer after each Wr_vld / Rd_req.
`timescale 1ns/1ps

module i2c_slave_gen2 #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Sclk,
    input  logic              Sda_in,
    output logic              Sda_oe,
    output logic              Sda_o,
    output logic              rw_flag,
    output logic              Wr_vld,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [7:0]        Wr_data,
    output logic              Rd_req,
    output logic [ADDR_W-1:0] Rd_addr,
    input  logic [7:0]        Rd_data,
    output logic              Rd_vld,
    output logic              busy
);

`ifdef I2C_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int FCW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int ADDR_BYTES = ADDR_W / 8;

    // state    | meaning
    // IDLE     | waiting for START
    // DEV      | receiving device address + R/W
    // DEV_ACK  | driving ACK for device address
    // ADDR     | receiving a register address byte
    // ADDR_ACK | driving ACK for an address byte
    // WR       | receiving a write data byte
    // WR_ACK   | driving ACK for a write data byte
    // RD       | shifting out a read data byte
    // RD_ACK   | sampling master ACK/NACK
    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_ADDR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK
    } state_t;

    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_filt;
    logic [FCW-1:0] r_fcnt [2];
    logic           r_scl_d;
    logic           r_sda_d;

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_abyte_left;
    logic [1:0]        r_rd_pipe;

    logic              w_scl;
    logic              w_sda;
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_start;
    logic              w_stop;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_ptr_load;

    // index 0 = Sclk, 1 = Sda; a change is accepted after FILT_LEN stable cycles
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_filt  <= 2'b11;
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
            for (int i = 0; i < 2; i++) r_fcnt[i] <= FCW'(FILT_LEN - 1);
        end else begin
            r_sync1 <= {Sda_in, Sclk};
            r_sync2 <= r_sync1;
            r_scl_d <= r_filt[0];
            r_sda_d <= r_filt[1];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= FCW'(FILT_LEN - 1);
                end else if (r_fcnt[i] == '0) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= FCW'(FILT_LEN - 1);
                end else begin
                    r_fcnt[i] <= r_fcnt[i] - 1'b1;
                end
            end
        end
    end

    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    generate
        if (ADDR_W == 8) begin : g_ptr8
            assign w_ptr_load = w_byte;
        end else begin : g_ptr16
            assign w_ptr_load = {r_ptr[ADDR_W-9:0], w_byte};
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_ptr        <= '0;
            r_abyte_left <= 1'b0;
            r_rd_pipe    <= 2'b00;
            Sda_oe       <= 1'b0;
            Sda_o        <= 1'b1;
            rw_flag      <= 1'b0;
            Wr_vld       <= 1'b0;
            Wr_addr      <= '0;
            Wr_data      <= 8'd0;
            Rd_req       <= 1'b0;
            Rd_addr      <= '0;
            Rd_vld       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            Wr_vld    <= 1'b0;
            Rd_req    <= 1'b0;
            Rd_vld    <= 1'b0;
            r_rd_pipe <= {r_rd_pipe[0], Rd_req};
            // Rd_data is valid two cycles after the Rd_req pulse
            if (r_rd_pipe[1]) begin
                r_shift <= Rd_data;
                Rd_vld  <= 1'b1;
            end

            if (w_stop) begin
                r_state <= S_IDLE;
                Sda_oe  <= 1'b0;
                Sda_o   <= 1'b1;
                busy    <= 1'b0;
            end else if (w_start) begin
                r_state   <= S_DEV;
                r_bit_cnt <= 3'd0;
                Sda_oe    <= 1'b0;
                Sda_o     <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_DEV, S_ADDR, S_WR: begin
                        if (w_scl_fall) begin
                            Sda_oe <= 1'b0;
                            Sda_o  <= 1'b1;
                        end
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == S_DEV) begin
                                    if (w_byte[7:1] == DEV_ADDR) begin
                                        r_state <= S_DEV_ACK;
                                        rw_flag <= w_byte[0];
                                    end else begin
                                        r_state <= S_IDLE;
                                        busy    <= 1'b0;
                                    end
                                end else if (r_state == S_ADDR) begin
                                    r_ptr   <= w_ptr_load;
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    Wr_vld  <= 1'b1;
                                    Wr_addr <= r_ptr;
                                    Wr_data <= w_byte;
                                    if (AUTOINC) r_ptr <= r_ptr + 1'b1;
                                    r_state <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    S_DEV_ACK, S_ADDR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            Sda_oe <= 1'b1;
                            Sda_o  <= 1'b0;
                        end
                        // master samples the ACK on this rise; the next state's fall releases or drives data
                        if (w_scl_rise) begin
                            r_bit_cnt <= 3'd0;
                            if (r_state == S_DEV_ACK && rw_flag) begin
                                r_state <= S_RD;
                                Rd_req  <= 1'b1;
                                Rd_addr <= r_ptr;
                                if (AUTOINC) r_ptr <= r_ptr + 1'b1;
                            end else if (r_state == S_DEV_ACK) begin
                                r_state      <= S_ADDR;
                                r_abyte_left <= 1'(ADDR_BYTES - 1);
                            end else if (r_state == S_ADDR_ACK && r_abyte_left) begin
                                r_state      <= S_ADDR;
                                r_abyte_left <= 1'b0;
                            end else begin
                                r_state <= S_WR;
                            end
                        end
                    end
                    S_RD: begin
                        if (w_scl_fall) begin
                            Sda_oe  <= 1'b1;
                            Sda_o   <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b1};
                        end
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_state <= S_RD_ACK;
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_fall) begin
                            Sda_oe <= 1'b0;
                            Sda_o  <= 1'b1;
                        end
                        if (w_scl_rise) begin
                            r_bit_cnt <= 3'd0;
                            if (!w_sda) begin
                                r_state <= S_RD;
                                Rd_req  <= 1'b1;
                                Rd_addr <= r_ptr;
                                if (AUTOINC) r_ptr <= r_ptr + 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
